// File: rtl/root_bcd_converter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the binary-to-BCD converter that sits between the
// square-root core and the seven-segment drivers.
//   state_t    : converter FSM states (IDLE, CONV, DONE)
//   min_digits : number of decimal digits needed to show 2^width - 1
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no valid data, outputs forced to zero
        CONV = 2'd1,  // double-dabble iterations in progress
        DONE = 2'd2   // result published and held
    } state_t;

    // Decimal digit count of the largest unsigned value of the given width.
    function automatic int min_digits(input int width);
        longint max_val;
        int     digits;
        max_val = (longint'(1) << width) - longint'(1);
        digits  = 1;
        while (max_val >= 10) begin
            max_val = max_val / 10;
            digits  = digits + 1;
        end
        return digits;
    endfunction

endpackage

// File: rtl/root_bcd_converter_if.sv
// -----------------------------------------------------------------------------
// root_bcd_converter_if
// Bundle between the sqrt core (master) and the BCD converter (slave).
//   bin_in    : binary root value                      (master -> slave)
//   bin_valid : level, high while bin_in is valid       (master -> slave)
//   bcd_out   : packed BCD, units digit in [3:0]        (slave -> master)
//   bcd_valid : bcd_out holds the conversion of bin_in  (slave -> master)
//   busy      : conversion in progress                  (slave -> master)
// -----------------------------------------------------------------------------
interface root_bcd_converter_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic [WIDTH-1:0]    bin_in;
    logic                bin_valid;
    logic [4*DIGITS-1:0] bcd_out;
    logic                bcd_valid;
    logic                busy;

    modport master (
        output bin_in, bin_valid,
        input  bcd_out, bcd_valid, busy
    );

    modport slave (
        input  bin_in, bin_valid,
        output bcd_out, bcd_valid, busy
    );
endinterface

// File: rtl/root_bcd_converter_dabble.sv
// -----------------------------------------------------------------------------
// dabble_digit
// Combinational double-dabble correction cell: a BCD digit of 5 or more gets
// +3 so that the following left shift carries correctly into the next digit.
//   i_digit : BCD digit before correction
//   o_digit : corrected digit (4-bit add, no carry out; inputs never exceed 9)
// -----------------------------------------------------------------------------
module dabble_digit (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);
    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;
endmodule

// File: rtl/root_bcd_converter.sv
// -----------------------------------------------------------------------------
// root_bcd_converter
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Converts the sqrt root into packed decimal digits for HEX2/HEX1/HEX0 and
// forces the output to zero whenever the root is not valid.
//   clk   : rising-edge clock
//   reset : synchronous, active-high, priority over everything else
//   bus   : slave side of root_bcd_converter_if (bin_in/bin_valid in,
//           bcd_out/bcd_valid/busy out, all outputs registered)
// -----------------------------------------------------------------------------
module root_bcd_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    root_bcd_converter_if.slave   bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SH_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
        $error("root_bcd_converter: DIGITS too small to hold 2^WIDTH-1");
    end

    state_t            r_state;
    logic [WIDTH-1:0]  r_cap;
    logic [SH_W-1:0]   r_shreg;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_prev_valid;
    logic [BCD_W-1:0]  r_bcd_out;
    logic              r_bcd_valid;
    logic              r_busy;

    logic [SH_W-1:0]   w_adj;
    logic [SH_W-1:0]   w_shifted;
    logic              w_start;

    // Digit fields sit above the binary field; only they get corrected.
    for (genvar d = 0; d < DIGITS; d++) begin : g_dabble
        dabble_digit u_digit (
            .i_digit (r_shreg[WIDTH+4*d +: 4]),
            .o_digit (w_adj[WIDTH+4*d +: 4])
        );
    end
    assign w_adj[WIDTH-1:0] = r_shreg[WIDTH-1:0];

    // The MSB shifted out is always zero given the DIGITS constraint.
    assign w_shifted = w_adj << 1;

    // A fresh rise of valid, or a new root while valid stays high.
    assign w_start = bus.bin_valid && (!r_prev_valid || (bus.bin_in != r_cap));

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cap        <= '0;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_prev_valid <= 1'b0;
            r_bcd_out    <= '0;
            r_bcd_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_prev_valid <= bus.bin_valid;
            if (!bus.bin_valid) begin
                // Abort from any state; a partial result is never published.
                r_state     <= IDLE;
                r_bcd_out   <= '0;
                r_bcd_valid <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (w_start) begin
                            r_cap       <= bus.bin_in;
                            r_shreg     <= {{BCD_W{1'b0}}, bus.bin_in};
                            r_cnt       <= '0;
                            r_bcd_valid <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= CONV;
                        end
                    end
                    CONV: begin
                        r_shreg <= w_shifted;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            r_bcd_out   <= w_shifted[SH_W-1 -: BCD_W];
                            r_bcd_valid <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= DONE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.bcd_out   = r_bcd_out;
    assign bus.bcd_valid = r_bcd_valid;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_root_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_root_bcd_converter
// Self-checking bench for root_bcd_converter: constant vector table, hand
// sequences for hold / abort / reset corners, and a full 0..255 sweep against
// a decimal reference model. Expected results travel through a scoreboard
// queue from the point a conversion is started to the point bcd_valid rises.
// -----------------------------------------------------------------------------
module tb_root_bcd_converter;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int LIMIT  = 20;

    typedef struct {
        logic [WIDTH-1:0]    bin;
        logic [4*DIGITS-1:0] exp;
    } vec_t;

    logic clk;
    logic reset;

    root_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    root_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                  n_checks = 0;
    int                  n_errors = 0;
    logic [4*DIGITS-1:0] exp_q[$];
    logic [WIDTH-1:0]    last_v = '0;
    vec_t                vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decimal reference model, digit by digit.
    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] d0, d1, d2;
        d0 = 4'(v % 10);
        d1 = 4'((v / 10) % 10);
        d2 = 4'(v / 100);
        return {d2, d1, d0};
    endfunction

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.bcd_valid !== 1'b1 && cycles < LIMIT) begin
            tick();
            cycles++;
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_out"},   32'(bus.bcd_out),   32'h0);
        check({name, "_valid"}, 32'(bus.bcd_valid), 32'h0);
        check({name, "_busy"},  32'(bus.busy),      32'h0);
    endtask

    // Start one conversion (rise of valid, or change of value while valid)
    // and compare the published result against the scoreboard head.
    task automatic convert(input logic [WIDTH-1:0] v, input logic [11:0] exp,
                           input bit drop_first, input string name);
        int                  cyc;
        logic [4*DIGITS-1:0] want;
        if (bus.bin_valid && (drop_first || v == last_v)) begin
            bus.bin_valid = 1'b0;
            tick();
        end
        bus.bin_in    = v;
        bus.bin_valid = 1'b1;
        exp_q.push_back(exp);
        tick();
        check({name, "_busy_start"},  32'(bus.busy),      32'h1);
        check({name, "_valid_start"}, 32'(bus.bcd_valid), 32'h0);
        wait_done(cyc);
        check({name, "_latency"},   32'(cyc),      32'(WIDTH));
        check({name, "_busy_done"}, 32'(bus.busy), 32'h0);
        if (exp_q.size() == 0) begin
            check({name, "_queue"}, 32'h0, 32'h1);
        end else begin
            want = exp_q.pop_front();
            check({name, "_bcd"}, 32'(bus.bcd_out), 32'(want));
        end
        last_v = v;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{bin: 8'd255, exp: 12'h255};
        vecs[1] = '{bin: 8'd0,   exp: 12'h000};
        vecs[2] = '{bin: 8'd16,  exp: 12'h016};
        vecs[3] = '{bin: 8'd99,  exp: 12'h099};
        vecs[4] = '{bin: 8'd100, exp: 12'h100};
        vecs[5] = '{bin: 8'd9,   exp: 12'h009};
        vecs[6] = '{bin: 8'd10,  exp: 12'h010};
        vecs[7] = '{bin: 8'd199, exp: 12'h199};
        vecs[8] = '{bin: 8'd128, exp: 12'h128};
        vecs[9] = '{bin: 8'd250, exp: 12'h250};

        reset         = 1'b1;
        bus.bin_in    = '0;
        bus.bin_valid = 1'b0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        tick();
        check_idle("idle_after_reset");

        // Table: first entry enters by a rise of valid, the rest by value change.
        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].bin, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
        end

        // DONE holds while the same value stays valid.
        convert(8'd15, 12'h015, 1'b0, "hold15");
        for (int i = 0; i < 3; i++) tick();
        check("hold_valid", 32'(bus.bcd_valid), 32'h1);
        check("hold_out",   32'(bus.bcd_out),   32'h015);
        check("hold_busy",  32'(bus.busy),      32'h0);
        // Value change with valid held high: valid drops, 0x200 after 8 cycles.
        convert(8'd200, 12'h200, 1'b0, "change200");

        // Abort mid-conversion: valid falls during CONV cycle 4.
        bus.bin_valid = 1'b0;
        tick();
        bus.bin_in    = 8'd123;
        bus.bin_valid = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        check("abort_busy_before", 32'(bus.busy), 32'h1);
        bus.bin_valid = 1'b0;
        tick();
        check_idle("abort");
        for (int i = 0; i < 10; i++) tick();
        check_idle("abort_quiet");
        convert(8'd37, 12'h037, 1'b0, "rerise37");

        // Reset during CONV.
        bus.bin_valid = 1'b0;
        tick();
        bus.bin_in    = 8'd250;
        bus.bin_valid = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_idle("reset_conv");
        reset         = 1'b0;
        bus.bin_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check_idle("reset_conv_quiet");
        convert(8'd77, 12'h077, 1'b0, "after_reset77");

        // Reset during DONE.
        reset = 1'b1;
        tick();
        check_idle("reset_done");
        reset         = 1'b0;
        bus.bin_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check_idle("reset_done_quiet");

        // Exhaustive sweep; every fourth value re-enters through a valid rise.
        for (int v = 0; v < 256; v++) begin
            convert(8'(v), to_bcd(v), (v % 4) == 0, $sformatf("sweep%0d", v));
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
